fifo_tx_arbiter: RTL and testbench

//  Shares the single write port of the TX byte FIFO among N byte-stream requesters.

---
 rtl/uart_cfg_pkg.sv | 12 +
 rtl/rr_pick.sv | 32 +++
 rtl/fifo_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_tx_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared configuration for the UART TX path: arbiter FSM states and
// the default byte width of the TX FIFO word.
package uart_cfg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set bit of req scanning ptr+1 .. ptr+N.
// Ports: req[N] in, ptr in; gnt[N] one-hot out, idx out, any out.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    int s;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        s   = 0;
        for (int k = 1; k <= N; k++) begin
            // Modulo keeps the scan correct for non-power-of-2 N.
            s = (int'(ptr) + k) % N;
            if (!any && req[s]) begin
                any    = 1'b1;
                gnt[s] = 1'b1;
                idx    = PW'(s);
            end
        end
    end

endmodule

// File: rtl/fifo_tx_arbiter.sv
// Round-robin, packet-locked arbiter for the TX byte FIFO write port,
// with an idle-owner watchdog.
// Ports: clk, reset (async, active-high); req_valid/req_data/req_last in,
// req_ready out; fifo_full in; fifo_wr/fifo_w_data out; grant, busy,
// timeout status out.
module fifo_tx_arbiter
    import uart_cfg_pkg::*;
#(
    parameter int N        = 4,
    parameter int B        = BYTE_W,
    parameter int HOLD_MAX = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [N*B-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    input  logic           fifo_full,
    output logic           fifo_wr,
    output logic [B-1:0]   fifo_w_data,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic           timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(HOLD_MAX);
    localparam logic [CW-1:0] CNT_TOP = CW'(HOLD_MAX - 1);

    state_t          state;
    state_t          state_nx;
    logic [N-1:0]    grant_q;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   rr_ptr;
    logic [CW-1:0]   idle_cnt;

    logic [N-1:0]    pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    logic            own_valid;
    logic            own_last;
    logic [B-1:0]    own_data;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign grant     = grant_q;
    assign own_valid = |(req_valid & grant_q);
    assign own_last  = |(req_last & grant_q);

    always_comb begin
        own_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                own_data = req_data[i*B +: B];
            end
        end
    end

    // Outputs are combinational from state, so an async reset
    // clears grant, ready and write strobe immediately.
    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        req_ready   = '0;
        fifo_wr     = 1'b0;
        fifo_w_data = '0;
        timeout     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                busy        = 1'b1;
                req_ready   = grant_q & {N{~fifo_full}};
                fifo_wr     = own_valid & ~fifo_full;
                fifo_w_data = own_data;
                // Only an absent owner counts toward the watchdog;
                // a valid owner stalled by fifo_full never expires.
                timeout     = ~own_valid & (idle_cnt == CNT_TOP);
                if ((fifo_wr & own_last) | timeout) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= '0;
            owner    <= '0;
            rr_ptr   <= PW'(N - 1);
            idle_cnt <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_q  <= pick_gnt;
                        owner    <= pick_idx;
                        idle_cnt <= '0;
                    end
                end
                XFER: begin
                    if (state_nx == IDLE) begin
                        grant_q  <= '0;
                        rr_ptr   <= owner;
                        idle_cnt <= '0;
                    end else if (fifo_wr) begin
                        idle_cnt <= '0;
                    end else if (!own_valid) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Self-checking bench for fifo_tx_arbiter: queue-based sources, a
// cycle model of the arbitration rules, and a write-data scoreboard.
module tb_fifo_tx_arbiter;

    localparam int N  = 4;
    localparam int B  = 8;
    localparam int HM = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*B-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_wr;
    logic [B-1:0]   fifo_w_data;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    fifo_tx_arbiter #(
        .N        (N),
        .B        (B),
        .HOLD_MAX (HM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .grant       (grant),
        .busy        (busy),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_pct = 100;
    int full_pct = 0;
    int last_acc = 0;

    logic [8:0] srcq [N][$];
    logic [7:0] exp_q [$];
    int         gseq [$];
    int         tgap [$];
    logic [N-1:0] acc = '0;
    logic [N-1:0] prev_g = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic push_pkt(input int s, input int len,
                            input logic [7:0] base);
        for (int k = 0; k < len; k++) begin
            srcq[s].push_back({(k == len - 1), base + 8'(k)});
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            #3;
            n++;
            done = !busy;
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() != 0) done = 0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_%s still active after %0d cycles",
                     nm, budget);
        end
    endtask

    task automatic wait_grant(input logic [N-1:0] g, input int budget,
                              input string nm);
        int n;
        n = 0;
        while (grant !== g && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk(nm, grant, g);
    endtask

    // Sources: pop on handshake seen last cycle, then present the next byte.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (srcq[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                req_valid[i]      = 1'b1;
                req_data[i*B +: B] = srcq[i][0][7:0];
                req_last[i]       = srcq[i][0][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*B +: B] = 8'($urandom);
                req_last[i]       = 1'($urandom);
            end
        end
        fifo_full = ($urandom_range(99) < full_pct);
    end

    // Reference model of the arbitration rules.
    int own = -1;
    int ptr = N - 1;
    int idle = 0;

    initial forever begin
        logic         ev, ew, et;
        logic [N-1:0] eg;
        @(negedge clk);
        cyc++;
        if (reset) begin
            own = -1;
            ptr = N - 1;
            idle = 0;
            acc = '0;
            continue;
        end
        eg = '0;
        if (own >= 0) eg[own] = 1'b1;
        ev = (own >= 0) && req_valid[own];
        ew = ev && !fifo_full;
        et = (own >= 0) && !req_valid[own] && (idle == HM - 1);
        chk("grant", grant, eg);
        chk("busy", busy, own >= 0);
        chk("timeout", timeout, et);
        chk("fifo_wr", fifo_wr, ew);
        chk("req_ready", req_ready, fifo_full ? '0 : eg);
        if (ew) exp_q.push_back(req_data[own*B +: B]);
        acc = req_valid & req_ready;
        if (own < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (own < 0 && req_valid[(ptr + k) % N]) begin
                    own = (ptr + k) % N;
                    idle = 0;
                end
            end
        end else if ((ew && req_last[own]) || et) begin
            ptr = own;
            own = -1;
        end else if (ew) begin
            idle = 0;
        end else if (!ev) begin
            idle++;
        end
    end

    // Monitor: scoreboard of written bytes, grant order, watchdog gap.
    initial forever begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (fifo_wr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_data unexpected write actual=%0h expected=none",
                             fifo_w_data);
                end else begin
                    chk("wr_data", fifo_w_data, exp_q.pop_front());
                end
                last_acc = cyc;
            end
            if (timeout) tgap.push_back(cyc - last_acc);
            if (grant != 0 && prev_g == 0) begin
                for (int i = 0; i < N; i++) begin
                    if (grant[i]) gseq.push_back(i);
                end
            end
        end
        prev_g = grant;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_rr [5];
        exp_rr = '{0, 1, 2, 3, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_wdata", fifo_w_data, 0);
        @(posedge clk);
        #3 reset = 1'b0;

        // Round-robin from reset, one-byte packets.
        @(negedge clk);
        #3;
        gseq.delete();
        for (int s = 0; s < N; s++) push_pkt(s, 1, 8'h10 + 8'(s));
        push_pkt(0, 1, 8'h14);
        wait_drain(200, "rr");
        chk("rr_count", gseq.size(), 5);
        for (int i = 0; i < 5 && i < gseq.size(); i++) begin
            chk("rr_order", gseq[i], exp_rr[i]);
        end

        // Single source, three bytes.
        gseq.delete();
        srcq[1].push_back({1'b0, 8'hA1});
        srcq[1].push_back({1'b0, 8'hA2});
        srcq[1].push_back({1'b1, 8'hA3});
        wait_drain(200, "single");
        chk("single_grant_cnt", gseq.size(), 1);
        if (gseq.size() > 0) chk("single_owner", gseq[0], 1);

        // Backpressure mid-packet.
        tgap.delete();
        push_pkt(0, 6, 8'h30);
        repeat (3) @(negedge clk);
        full_pct = 100;
        repeat (10) @(negedge clk);
        full_pct = 0;
        wait_drain(200, "bp");
        chk("bp_no_timeout", tgap.size(), 0);

        // Watchdog: src2 stalls mid-packet, src3 waits.
        tgap.delete();
        gseq.delete();
        srcq[2].push_back({1'b0, 8'hC0});
        push_pkt(3, 2, 8'hD0);
        wait_drain(300, "wdog");
        chk("wdog_pulses", tgap.size(), 1);
        if (tgap.size() > 0) chk("wdog_gap", tgap[0], HM);
        chk("wdog_grants", gseq.size(), 2);
        if (gseq.size() > 1) begin
            chk("wdog_first", gseq[0], 2);
            chk("wdog_next", gseq[1], 3);
        end

        // Packet lock: src0 raises valid while src3 owns the port.
        gseq.delete();
        push_pkt(3, 4, 8'hE0);
        wait_grant(4'b1000, 50, "lock_grant3");
        push_pkt(0, 1, 8'hF0);
        wait_drain(200, "lock");
        chk("lock_grants", gseq.size(), 2);
        if (gseq.size() > 1) begin
            chk("lock_first", gseq[0], 3);
            chk("lock_next", gseq[1], 0);
        end

        // Reset mid-packet with src0 owning and valid.
        push_pkt(0, 5, 8'h50);
        wait_grant(4'b0001, 50, "rstmid_grant0");
        push_pkt(1, 2, 8'h60);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_grant", grant, 0);
        chk("rstmid_fifo_wr", fifo_wr, 0);
        chk("rstmid_ready", req_ready, 0);
        gseq.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        wait_drain(300, "rstmid");
        chk("rstmid_cnt", gseq.size() >= 1, 1);
        if (gseq.size() > 0) chk("rstmid_first", gseq[0], 0);

        // Randomized traffic with valid gaps and backpressure.
        valid_pct = 70;
        full_pct = 20;
        repeat (1500) begin
            @(negedge clk);
            #3;
            for (int s = 0; s < N; s++) begin
                if (srcq[s].size() < 2 && $urandom_range(3) == 0) begin
                    push_pkt(s, int'($urandom_range(1, 4)), 8'($urandom));
                end
            end
        end
        valid_pct = 100;
        full_pct = 0;
        wait_drain(2000, "random");
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
